// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction-fetch stage. Owns the PC, addresses the instruction
//            ROM combinationally and registers the PC/instruction pair into
//            the IF/ID pipeline register. Handles stall, redirect and the
//            misaligned-redirect fault.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,            // synchronous, active-low
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;
  logic        r_id_valid;
  logic        r_fault;

  logic [31:0] w_pc_next_seq;
  logic        w_target_misaligned;

  // Sequential next PC wraps modulo 2^32 with no overflow indication.
  assign w_pc_next_seq       = r_pc + PC_STEP;
  assign w_target_misaligned = (redirect_target[1:0] != 2'b00);

  // Fetch FSM: owns PC, IF/ID register and sticky fault flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_START;
      r_pc       <= PC_RESET;
      r_id_pc    <= 32'h0000_0000;
      r_id_instr <= BUBBLE;
      r_id_valid <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        // The ROM read of PC_RESET is already in flight; take it
        // unconditionally so the pipeline always starts with a real fetch.
        S_START: begin
          r_id_instr <= imem_data;
          r_id_pc    <= r_pc;
          r_id_valid <= 1'b1;
          r_pc       <= w_pc_next_seq;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          if (redirect) begin
            // The word fetched this cycle is on the wrong path: flush it.
            r_id_valid <= 1'b0;
            r_id_instr <= BUBBLE;
            if (w_target_misaligned) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pc <= redirect_target;
            end
          end else if (!stall) begin
            r_id_instr <= imem_data;
            r_id_pc    <= r_pc;
            r_id_valid <= 1'b1;
            r_pc       <= w_pc_next_seq;
          end
        end
        // Frozen until reset; IF/ID already invalidated on entry.
        S_FAULT: begin
          r_fault    <= 1'b1;
          r_id_valid <= 1'b0;
        end
        default: begin
          r_state <= S_FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign id_pc     = r_id_pc;
  assign id_instr  = r_id_instr;
  assign id_valid  = r_id_valid;
  assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage. Stimulus records carry the
//            expected post-edge outputs; expectations are queued when a
//            record is driven and popped after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        fault;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc              (pc),
    .id_pc           (id_pc),
    .id_instr        (id_instr),
    .id_valid        (id_valid),
    .fault           (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address-dependent ROM contents so every word is distinguishable.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = rom(imem_addr);

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rd;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [31:0] eidpc;
    logic [31:0] einstr;
    logic        evalid;
    logic        efault;
    logic        chk_idpc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic rst, input logic stl, input logic rd,
                              input logic [31:0] tgt, input logic [31:0] epc,
                              input logic [31:0] eidpc, input logic [31:0] einstr,
                              input logic evalid, input logic efault,
                              input logic chk_idpc);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rd = rd; v.tgt = tgt;
    v.epc = epc; v.eidpc = eidpc; v.einstr = einstr;
    v.evalid = evalid; v.efault = efault; v.chk_idpc = chk_idpc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one record, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    reset           = ~v.rst;
    stall           = v.stl;
    redirect        = v.rd;
    redirect_target = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", idx);
    end else begin
      e = sb.pop_front();
      chk("pc",        idx, pc,        e.epc);
      chk("imem_addr", idx, imem_addr, e.epc);
      chk("id_instr",  idx, id_instr,  e.einstr);
      chk("id_valid",  idx, {31'b0, id_valid}, {31'b0, e.evalid});
      chk("fault",     idx, {31'b0, fault},    {31'b0, e.efault});
      if (e.chk_idpc) chk("id_pc", idx, id_pc, e.eidpc);
    end
  endtask

  initial begin
    logic [31:0] prev_pc;
    vec_t        v;

    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;

    //   rst stl rd tgt           pc            id_pc         id_instr            v  f  chk_idpc
    add(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,              0, 0, 1); // reset
    add(0, 0, 0, 32'h0,        32'h4,        32'h0,        rom(32'h0),         1, 0, 1); // START
    add(0, 0, 0, 32'h0,        32'h8,        32'h4,        rom(32'h4),         1, 0, 1);
    add(0, 0, 0, 32'h0,        32'hC,        32'h8,        rom(32'h8),         1, 0, 1);
    add(0, 1, 0, 32'h0,        32'hC,        32'h8,        rom(32'h8),         1, 0, 1); // stall x3
    add(0, 1, 0, 32'h0,        32'hC,        32'h8,        rom(32'h8),         1, 0, 1);
    add(0, 1, 0, 32'h0,        32'hC,        32'h8,        rom(32'h8),         1, 0, 1);
    add(0, 0, 0, 32'h0,        32'h10,       32'hC,        rom(32'hC),         1, 0, 1);
    add(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,              0, 0, 1); // reset
    add(0, 0, 0, 32'h0,        32'h4,        32'h0,        rom(32'h0),         1, 0, 1);
    add(0, 0, 0, 32'h0,        32'h8,        32'h4,        rom(32'h4),         1, 0, 1);
    add(0, 0, 1, 32'h14,       32'h14,       32'h0,        32'h0,              0, 0, 0); // jump
    add(0, 0, 0, 32'h0,        32'h18,       32'h14,       rom(32'h14),        1, 0, 1);
    add(0, 1, 1, 32'h8,        32'h8,        32'h0,        32'h0,              0, 0, 0); // rd beats stall
    add(0, 1, 0, 32'h0,        32'h8,        32'h0,        32'h0,              0, 0, 0); // stall on bubble
    add(0, 0, 0, 32'h0,        32'hC,        32'h8,        rom(32'h8),         1, 0, 1);
    add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,              0, 0, 0);
    add(0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1, 0, 1); // wrap
    add(0, 0, 0, 32'h0,        32'h4,        32'h0,        rom(32'h0),         1, 0, 1);
    add(0, 0, 1, 32'h6,        32'h4,        32'h0,        32'h0,              0, 1, 0); // misaligned
    add(0, 0, 1, 32'h10,       32'h4,        32'h0,        32'h0,              0, 1, 0);
    add(0, 0, 0, 32'h0,        32'h4,        32'h0,        32'h0,              0, 1, 0);
    add(0, 1, 0, 32'h0,        32'h4,        32'h0,        32'h0,              0, 1, 0);
    add(1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,              0, 0, 1); // exit fault
    add(0, 1, 1, 32'h40,       32'h4,        32'h0,        rom(32'h0),         1, 0, 1); // START ignores
    add(0, 1, 0, 32'h0,        32'h4,        32'h0,        rom(32'h0),         1, 0, 1);
    add(1, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,              0, 0, 1); // reset mid-stall
    add(0, 0, 0, 32'h0,        32'h4,        32'h0,        rom(32'h0),         1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Free-run: each edge the word at the previous pc lands in IF/ID.
    prev_pc = 32'h4;
    for (int i = 0; i < 8; i++) begin
      v.rst = 0; v.stl = 0; v.rd = 0; v.tgt = 32'h0;
      v.epc = prev_pc + 32'd4; v.eidpc = prev_pc; v.einstr = rom(prev_pc);
      v.evalid = 1; v.efault = 0; v.chk_idpc = 1;
      apply(v, 100 + i);
      prev_pc = prev_pc + 32'd4;
    end

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
